// File: rtl/data_mem_unit.sv
// Data-side memory stage: LDR/STR against a small synchronous data RAM and a memory-mapped GPIO register.
// Define GPIO_SYNC_EN to add a 2-flop synchronizer ahead of the gpio_state register.
module data_mem_unit #(
  parameter int RAM_WORDS = 31,
  parameter int GPIO_ADDR = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [4:0]  uop,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] gpio_in,
  output logic [31:0] d_cache,
  output logic [31:0] gpio_state,
  output logic [31:0] gpio_out,
  output logic        stall
);

  localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [4:0]  UOP_LDR   = 5'd10;
  localparam logic [4:0]  UOP_STR   = 5'd11;
  localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS);
  localparam logic [31:0] GPIO_A    = 32'(GPIO_ADDR);

  typedef enum logic {IDLE, RDATA} state_e;

  state_e         state_q;
  logic [31:0]    d_cache_q;
  logic [31:0]    gpio_out_q;
  logic [31:0]    gpio_state_q;
  logic [31:0]    mem [RAM_WORDS];

  logic           ram_hit, gpio_hit, is_ldr, is_str;
  logic           ld_ram, st_ram, st_gpio;
  logic [AW-1:0]  ram_idx;

  assign ram_hit  = addr < RAM_LIMIT;
  assign gpio_hit = addr == GPIO_A;
  assign is_ldr   = valid && (uop == UOP_LDR);
  assign is_str   = valid && (uop == UOP_STR);
  assign ram_idx  = addr[AW-1:0];

  // Stores presented while the held load completes (RDATA) are dropped.
  assign ld_ram  = is_ldr && ram_hit  && (state_q == IDLE) && !rst;
  assign st_ram  = is_str && ram_hit  && (state_q == IDLE) && !rst;
  assign st_gpio = is_str && gpio_hit && (state_q == IDLE);

  assign stall = ld_ram;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      d_cache_q  <= '0;
      gpio_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_ram) begin
            d_cache_q <= mem[ram_idx];
            state_q   <= RDATA;
          end
          if (st_gpio) gpio_out_q <= wdata;
        end
        RDATA:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (st_ram) mem[ram_idx] <= wdata;
  end

`ifdef GPIO_SYNC_EN
  logic [31:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      gpio_state_q <= '0;
    end else begin
      sync1_q      <= gpio_in;
      sync2_q      <= sync1_q;
      gpio_state_q <= sync2_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) gpio_state_q <= '0;
    else     gpio_state_q <= gpio_in;
  end
`endif

  assign d_cache    = d_cache_q;
  assign gpio_out   = gpio_out_q;
  assign gpio_state = gpio_state_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed vector bench for data_mem_unit; expected GPIO latency follows GPIO_SYNC_EN.
module tb_data_mem_unit;

`ifdef GPIO_SYNC_EN
  localparam int GPIO_LAT = 3;
`else
  localparam int GPIO_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, valid;
  logic [4:0]  uop;
  logic [31:0] addr, wdata, gpio_in;
  logic [31:0] d_cache, gpio_state, gpio_out;
  logic        stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_unit dut (
    .clk(clk), .rst(rst), .valid(valid), .uop(uop), .addr(addr), .wdata(wdata),
    .gpio_in(gpio_in), .d_cache(d_cache), .gpio_state(gpio_state),
    .gpio_out(gpio_out), .stall(stall)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  uop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic [31:0] exp_dcache;
    logic [31:0] exp_gout;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] u, input logic [31:0] a, input logic [31:0] w);
    valid = v; uop = u; addr = a; wdata = w;
  endtask

  initial begin
    // {valid, uop, addr, wdata, stall this cycle, d_cache after edge, gpio_out after edge}
    vecs[0]  = '{1'b1, 5'd11, 32'd5,  32'hDEADBEEF, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 5'd10, 32'd5,  32'h0,        1'b1, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 5'd10, 32'd5,  32'h0,        1'b0, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b1, 5'd11, 32'd32, 32'h000000A5, 1'b0, 32'hDEADBEEF, 32'hA5};
    vecs[4]  = '{1'b1, 5'd11, 32'd31, 32'hFFFFFFFF, 1'b0, 32'hDEADBEEF, 32'hA5};
    vecs[5]  = '{1'b1, 5'd10, 32'd31, 32'h0,        1'b0, 32'hDEADBEEF, 32'hA5};
    vecs[6]  = '{1'b1, 5'd10, 32'd32, 32'h0,        1'b0, 32'hDEADBEEF, 32'hA5};
    vecs[7]  = '{1'b1, 5'd11, 32'd30, 32'h7,        1'b0, 32'hDEADBEEF, 32'hA5};
    vecs[8]  = '{1'b1, 5'd10, 32'd30, 32'h0,        1'b1, 32'h7,        32'hA5};
    vecs[9]  = '{1'b1, 5'd10, 32'd30, 32'h0,        1'b0, 32'h7,        32'hA5};
    vecs[10] = '{1'b1, 5'd11, 32'd0,  32'h11,       1'b0, 32'h7,        32'hA5};
    vecs[11] = '{1'b1, 5'd11, 32'd1,  32'h22,       1'b0, 32'h7,        32'hA5};
    vecs[12] = '{1'b1, 5'd10, 32'd0,  32'h0,        1'b1, 32'h11,       32'hA5};
    vecs[13] = '{1'b1, 5'd10, 32'd0,  32'h0,        1'b0, 32'h11,       32'hA5};
    vecs[14] = '{1'b1, 5'd10, 32'd1,  32'h0,        1'b1, 32'h22,       32'hA5};
    vecs[15] = '{1'b1, 5'd10, 32'd1,  32'h0,        1'b0, 32'h22,       32'hA5};
    vecs[16] = '{1'b0, 5'd10, 32'd0,  32'h0,        1'b0, 32'h22,       32'hA5};
    vecs[17] = '{1'b0, 5'd11, 32'd0,  32'hBAD,      1'b0, 32'h22,       32'hA5};
    vecs[18] = '{1'b1, 5'd10, 32'd0,  32'h0,        1'b1, 32'h11,       32'hA5};
    vecs[19] = '{1'b1, 5'd11, 32'd0,  32'h999,      1'b0, 32'h11,       32'hA5};
    vecs[20] = '{1'b1, 5'd10, 32'd0,  32'h0,        1'b1, 32'h11,       32'hA5};
    vecs[21] = '{1'b1, 5'd10, 32'd0,  32'h0,        1'b0, 32'h11,       32'hA5};
    vecs[22] = '{1'b1, 5'd5,  32'd0,  32'h0,        1'b0, 32'h11,       32'hA5};
    vecs[23] = '{1'b1, 5'd11, 32'd33, 32'h123,      1'b0, 32'h11,       32'hA5};
    vecs[24] = '{1'b1, 5'd10, 32'd5,  32'h0,        1'b1, 32'hDEADBEEF, 32'hA5};
    vecs[25] = '{1'b1, 5'd10, 32'd5,  32'h0,        1'b0, 32'hDEADBEEF, 32'hA5};

    // Reset with live inputs that would otherwise disturb every output.
    rst = 1'b1;
    gpio_in = 32'hFFFFFFFF;
    drive(1'b1, 5'd10, 32'd3, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_stall",      {31'b0, stall}, 32'h0);
    chk("rst_d_cache",    d_cache,        32'h0);
    chk("rst_gpio_out",   gpio_out,       32'h0);
    chk("rst_gpio_state", gpio_state,     32'h0);

    @(negedge clk);
    rst = 1'b0;
    gpio_in = 32'h0;
    drive(1'b0, 5'd0, 32'd0, 32'h0);
    repeat (GPIO_LAT + 1) @(posedge clk);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].uop, vecs[i].addr, vecs[i].wdata);
      #1;
      chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].exp_stall});
      @(posedge clk); #1;
      chk($sformatf("v%0d_d_cache", i),  d_cache,  vecs[i].exp_dcache);
      chk($sformatf("v%0d_gpio_out", i), gpio_out, vecs[i].exp_gout);
    end

    // Reset while a load sits in RDATA: load abandoned, stall forced low.
    @(negedge clk);
    drive(1'b1, 5'd10, 32'd30, 32'h0);
    #1 chk("rdrst_issue_stall", {31'b0, stall}, 32'h1);
    @(posedge clk); #1;
    chk("rdrst_load_data", d_cache, 32'h7);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rdrst_stall_in_rst", {31'b0, stall}, 32'h0);
    @(posedge clk); #1;
    chk("rdrst_d_cache",  d_cache,  32'h0);
    chk("rdrst_gpio_out", gpio_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rdrst_idle_stall", {31'b0, stall}, 32'h1);
    @(posedge clk); #1;
    chk("rdrst_reload", d_cache, 32'h7);

    // GPIO input path latency; loads from the GPIO address never stall.
    @(negedge clk);
    drive(1'b1, 5'd10, 32'd32, 32'h0);
    gpio_in = 32'h1234;
    #1 chk("gpio_ld_stall", {31'b0, stall}, 32'h0);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      chk($sformatf("gpio_state_e%0d", e), gpio_state, (e >= GPIO_LAT) ? 32'h1234 : 32'h0);
      chk($sformatf("gpio_ld_stall_e%0d", e), {31'b0, stall}, 32'h0);
    end

    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 32'h0);
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
